// File: rtl/super_i3_bch_outer_encoder_pkg.sv
//==============================================================================
// Module   : super_i3_bch_outer_encoder_pkg
// Function : Shared types and constants for the I.3 outer BCH(3860,3824) encoder.
// Revision : 1.0 - initial release
//==============================================================================
`default_nettype none

package super_i3_bch_outer_encoder_pkg;

    localparam int cM           = 12;
    localparam logic [12:0] cIRRPOL = 13'h1053;   // x^12 + x^6 + x^4 + x + 1
    localparam int cT           = 3;
    localparam int cN           = 3860;
    localparam int cK           = 3824;
    localparam int cPAR_W       = cN - cK;
    localparam int cINFO_WORDS  = 239;
    localparam int cFRAME_WORDS = cINFO_WORDS + 3;

    typedef logic [15:0]       dat_t;
    typedef logic [cPAR_W-1:0] rem_t;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        DATA   = 2'd1,
        PARITY = 2'd2
    } state_t;

    function automatic logic [cM-1:0] gf_mul(input logic [cM-1:0] a, input logic [cM-1:0] b);
        logic [cM-1:0] r;
        r = '0;
        for (int i = cM - 1; i >= 0; i--) begin
            r = {r[cM-2:0], 1'b0} ^ (r[cM-1] ? cIRRPOL[cM-1:0] : '0);
            if (b[i]) r = r ^ a;
        end
        return r;
    endfunction

    // Generator = product of (x + beta) over the conjugates of alpha, alpha^3, alpha^5
    function automatic logic [cPAR_W:0] gen_poly();
        logic [cM-1:0]     c [0:cPAR_W];
        logic [cM-1:0]     beta;
        logic [cPAR_W:0]   g;
        for (int j = 0; j <= cPAR_W; j++) c[j] = '0;
        c[0] = 1;
        for (int s = 0; s < cT; s++) begin
            beta = 2;
            for (int e = 0; e < 2 * s; e++) beta = gf_mul(beta, 2);
            for (int k = 0; k < cM; k++) begin
                for (int j = cPAR_W; j > 0; j--) c[j] = c[j-1] ^ gf_mul(c[j], beta);
                c[0] = gf_mul(c[0], beta);
                beta = gf_mul(beta, beta);
            end
        end
        for (int j = 0; j <= cPAR_W; j++) g[j] = c[j][0];
        return g;
    endfunction

    localparam logic [cPAR_W:0] cGEN_POLY = gen_poly();

endpackage

`default_nettype wire

// File: rtl/super_i3_bch_outer_encoder_if.sv
//==============================================================================
// Module   : super_i3_bch_outer_encoder_if
// Function : Information-in / codeword-out stream bundle of the outer encoder.
// Revision : 1.0 - initial release
//==============================================================================
`default_nettype none

interface super_i3_bch_outer_encoder_if #(
    parameter int pENC_NUM = 8,
    parameter int pDAT_W   = 16
);
    logic                             isop;
    logic                             ival;
    logic                             ieop;
    logic [pENC_NUM-1:0][pDAT_W-1:0]  idat;
    logic                             ordy;
    logic                             oval;
    logic                             osop;
    logic                             oeop;
    logic [pENC_NUM-1:0][pDAT_W-1:0]  odat;
    logic                             oframe_err;

    modport master (
        output isop, ival, ieop, idat,
        input  ordy, oval, osop, oeop, odat, oframe_err
    );

    modport slave (
        input  isop, ival, ieop, idat,
        output ordy, oval, osop, oeop, odat, oframe_err
    );
endinterface

`default_nettype wire

// File: rtl/super_i3_bch_outer_enc_lfsr.sv
//==============================================================================
// Module   : super_i3_bch_outer_enc_lfsr
// Function : One lane's 16-bit-parallel BCH remainder update (MSB first in time).
// Revision : 1.0 - initial release
//==============================================================================
`default_nettype none

module super_i3_bch_outer_enc_lfsr
    import super_i3_bch_outer_encoder_pkg::*;
(
    input  rem_t irem,
    input  dat_t idat,
    output rem_t orem
);
    rem_t w_rem;
    logic w_fb;

    always_comb begin
        w_rem = irem;
        w_fb  = 1'b0;
        for (int b = 15; b >= 0; b--) begin
            w_fb  = w_rem[cPAR_W-1] ^ idat[b];
            w_rem = {w_rem[cPAR_W-2:0], 1'b0} ^ ({cPAR_W{w_fb}} & cGEN_POLY[cPAR_W-1:0]);
        end
    end

    assign orem = w_rem;
endmodule

`default_nettype wire

// File: rtl/super_i3_bch_outer_encoder.sv
//==============================================================================
// Module   : super_i3_bch_outer_encoder
// Function : pENC_NUM-lane systematic BCH(3860,3824) encoder, 239 in / 242 out words.
//            Optional frame-length check: SUPER_I3_BCH_OUTER_ENC_LEN_CHECK_EN.
// Revision : 1.0 - initial release
//==============================================================================
`default_nettype none

module super_i3_bch_outer_encoder
    import super_i3_bch_outer_encoder_pkg::*;
#(
    parameter int pENC_NUM = 8,
    parameter int pDAT_W   = 16
) (
    input  logic                        iclk,
    input  logic                        ireset,
    input  logic                        iclkena,
    super_i3_bch_outer_encoder_if.slave bus
);
    localparam logic [1:0] cPAR_LAST = 2'(cFRAME_WORDS - cINFO_WORDS - 1);

    state_t     r_state;
    state_t     w_state_nxt;
    logic [1:0] r_pcnt;
    logic       r_ordy;
    logic       r_oval;
    logic       r_osop;
    logic       r_oeop;
    logic       w_take;
    logic       w_in_par;
    logic       w_par_last;

    // In IDLE only a start-of-frame word is taken; anything else is dropped
    assign w_take     = bus.ival & r_ordy & (bus.isop | (r_state == DATA));
    assign w_in_par   = (r_state == PARITY);
    assign w_par_last = w_in_par & (r_pcnt == cPAR_LAST);

    always_ff @(posedge iclk or posedge ireset) begin
        if (ireset)       r_state <= IDLE;
        else if (iclkena) r_state <= w_state_nxt;
    end

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            IDLE, DATA: if (w_take) w_state_nxt = bus.ieop ? PARITY : DATA;
            PARITY:     if (r_pcnt == cPAR_LAST) w_state_nxt = IDLE;
            default:    w_state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge iclk or posedge ireset) begin
        if (ireset) begin
            r_pcnt <= '0;
            r_ordy <= 1'b1;
            r_oval <= 1'b0;
            r_osop <= 1'b0;
            r_oeop <= 1'b0;
        end else if (iclkena) begin
            r_pcnt <= w_in_par ? r_pcnt + 2'd1 : 2'd0;
            r_ordy <= (w_state_nxt != PARITY);
            r_oval <= w_take | w_in_par;
            r_osop <= w_take & bus.isop;
            r_oeop <= w_par_last;
        end
    end

    assign bus.ordy = r_ordy;
    assign bus.oval = r_oval;
    assign bus.osop = r_osop;
    assign bus.oeop = r_oeop;

    for (genvar i = 0; i < pENC_NUM; i++) begin : g_lane
        rem_t              r_rem;
        rem_t              w_base;
        rem_t              w_step;
        logic [pDAT_W-1:0] r_odat;
        logic [pDAT_W-1:0] w_odat_nxt;

        assign w_base = bus.isop ? '0 : r_rem;

        super_i3_bch_outer_enc_lfsr u_lfsr (
            .irem (w_base),
            .idat (bus.idat[i]),
            .orem (w_step)
        );

        always_comb begin
            w_odat_nxt = '0;
            if (w_in_par) begin
                case (r_pcnt)
                    2'd0:    w_odat_nxt = r_rem[35:20];
                    2'd1:    w_odat_nxt = r_rem[19:4];
                    default: w_odat_nxt = {12'h000, r_rem[3:0]};
                endcase
            end else if (w_take) begin
                w_odat_nxt = bus.idat[i];
            end
        end

        always_ff @(posedge iclk or posedge ireset) begin
            if (ireset) begin
                r_rem  <= '0;
                r_odat <= '0;
            end else if (iclkena) begin
                if (w_take) r_rem <= w_step;
                r_odat <= w_odat_nxt;
            end
        end

        assign bus.odat[i] = r_odat;
    end

`ifdef SUPER_I3_BCH_OUTER_ENC_LEN_CHECK_EN
    localparam logic [7:0] cLAST_IDX = 8'(cINFO_WORDS - 1);

    logic [7:0] r_wcnt;
    logic [7:0] w_idx;
    logic       r_len_bad;
    logic       r_oerr;

    // Saturating index of the word being taken, so long frames never alias to a good length
    always_comb begin
        w_idx = 8'd0;
        if (!bus.isop) w_idx = (r_wcnt == 8'hFF) ? 8'hFF : r_wcnt + 8'd1;
    end

    always_ff @(posedge iclk or posedge ireset) begin
        if (ireset) begin
            r_wcnt    <= '0;
            r_len_bad <= 1'b0;
            r_oerr    <= 1'b0;
        end else if (iclkena) begin
            if (w_take)            r_wcnt    <= w_idx;
            if (w_take & bus.ieop) r_len_bad <= (w_idx != cLAST_IDX);
            r_oerr <= (w_take & bus.isop & (r_state == DATA)) | (w_par_last & r_len_bad);
        end
    end

    assign bus.oframe_err = r_oerr;
`else
    assign bus.oframe_err = 1'b0;
`endif

endmodule

`default_nettype wire

// File: tb/tb_super_i3_bch_outer_encoder.sv
//==============================================================================
// Module   : tb_super_i3_bch_outer_encoder
// Function : Scoreboard bench for the outer BCH encoder (directed + random frames).
// Revision : 1.0 - initial release
//==============================================================================
`default_nettype none

module tb_super_i3_bch_outer_encoder;
    import super_i3_bch_outer_encoder_pkg::*;

    localparam int NL = 8;
`ifdef SUPER_I3_BCH_OUTER_ENC_LEN_CHECK_EN
    localparam bit LEN_EN = 1'b1;
`else
    localparam bit LEN_EN = 1'b0;
`endif

    logic iclk    = 1'b0;
    logic ireset  = 1'b1;
    logic iclkena = 1'b0;

    super_i3_bch_outer_encoder_if #(.pENC_NUM(NL), .pDAT_W(16)) bus ();

    super_i3_bch_outer_encoder #(.pENC_NUM(NL), .pDAT_W(16)) u_dut (
        .iclk    (iclk),
        .ireset  (ireset),
        .iclkena (iclkena),
        .bus     (bus)
    );

    always #5 iclk = ~iclk;

    typedef struct {
        logic                 sop;
        logic                 eop;
        logic                 err;
        logic [NL-1:0][15:0]  dat;
    } exp_t;

    exp_t        q[$];
    int          total = 0;
    int          bad   = 0;
    logic        m_in  = 1'b0;
    int          m_idx = 0;
    logic [36:0] m_rem [NL];
    bit          dir_en = 1'b0;
    logic [35:0] dir_par [NL];
    logic        en_q = 1'b0;
    int          run = 0;
    int          last_run = 0;
    bit          cnt_ordy = 1'b0;
    int          ordy_low = 0;

    task automatic chk(input string nm, input logic [127:0] act, input logic [127:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h want %0h", nm, act, exp);
        end
    endtask

    // Textbook long division: shift message bit in, subtract g when degree 36 appears
    function automatic logic [36:0] div_bit(input logic [36:0] r, input logic b);
        logic [36:0] n;
        n = {r[35:0], b};
        if (n[36]) n = n ^ cGEN_POLY;
        return n;
    endfunction

    task automatic model_accept(input logic sop, input logic eop, input logic [NL-1:0][15:0] d);
        exp_t        e;
        logic        err;
        logic [36:0] p;
        logic [35:0] par [NL];
        bit          take;
        take = 1'b0;
        err  = 1'b0;
        if (sop) begin
            err   = m_in;
            m_in  = 1'b1;
            m_idx = 0;
            for (int l = 0; l < NL; l++) m_rem[l] = '0;
            take  = 1'b1;
        end else if (m_in) begin
            m_idx = (m_idx < 255) ? m_idx + 1 : 255;
            take  = 1'b1;
        end
        if (take) begin
            for (int l = 0; l < NL; l++)
                for (int b = 15; b >= 0; b--) m_rem[l] = div_bit(m_rem[l], d[l][b]);
            e.sop = sop; e.eop = 1'b0; e.err = LEN_EN & err; e.dat = d;
            q.push_back(e);
            if (eop) begin
                for (int l = 0; l < NL; l++) begin
                    p = m_rem[l];
                    for (int z = 0; z < 36; z++) p = div_bit(p, 1'b0);
                    par[l] = dir_en ? dir_par[l] : p[35:0];
                end
                for (int w = 0; w < 3; w++) begin
                    e.sop = 1'b0;
                    e.eop = (w == 2);
                    e.err = (w == 2) & LEN_EN & (m_idx != 238);
                    for (int l = 0; l < NL; l++)
                        e.dat[l] = (w == 0) ? par[l][35:20] : (w == 1) ? par[l][19:4] : {12'h000, par[l][3:0]};
                    q.push_back(e);
                end
                m_in = 1'b0;
            end
        end
    endtask

    task automatic send(input logic sop, input logic eop, input logic [NL-1:0][15:0] d, input bit gapped);
        bit acc;
        acc = 1'b0;
        bus.ival = 1'b1; bus.isop = sop; bus.ieop = eop; bus.idat = d;
        for (int n = 0; n < 200 && !acc; n++) begin
            iclkena = gapped ? 1'($urandom_range(0, 1)) : 1'b1;
            @(negedge iclk);
            acc = bus.ordy && iclkena;
            @(posedge iclk); #1;
        end
        if (acc) model_accept(sop, eop, d);
        else begin
            total++; bad++;
            $display("FAIL accept_timeout: got ordy=%0b want word accepted", bus.ordy);
        end
        bus.ival = 1'b0; bus.isop = 1'b0; bus.ieop = 1'b0;
    endtask

    task automatic idle(input int n, input bit gapped);
        bus.ival = 1'b0;
        repeat (n) begin
            iclkena = gapped ? 1'($urandom_range(0, 1)) : 1'b1;
            @(posedge iclk); #1;
        end
    endtask

    // kind: 0 all-zero, 1 single one at last info bit of lane 0, 2 random
    task automatic send_frame(input int nw, input int kind, input bit gapped, input bit term);
        logic [NL-1:0][15:0] d;
        for (int w = 0; w < nw; w++) begin
            for (int l = 0; l < NL; l++) d[l] = (kind == 2) ? 16'($urandom()) : 16'h0000;
            if (kind == 1 && w == 238) d[0] = 16'h0001;
            send(w == 0, term && (w == nw - 1), d, gapped);
            if (gapped && $urandom_range(0, 3) == 0) idle(1, 1'b1);
        end
    endtask

    task automatic chk_reset_vals();
        chk("rst_oval", 128'(bus.oval), 128'd0);
        chk("rst_osop", 128'(bus.osop), 128'd0);
        chk("rst_oeop", 128'(bus.oeop), 128'd0);
        chk("rst_odat", 128'(bus.odat), 128'd0);
        chk("rst_oframe_err", 128'(bus.oframe_err), 128'd0);
        chk("rst_ordy", 128'(bus.ordy), 128'd1);
    endtask

    always @(posedge iclk) en_q <= iclkena;

    always @(negedge iclk) begin
        exp_t e;
        if (!ireset && en_q) begin
            if (bus.oval) begin
                run++;
                if (q.size() == 0) begin
                    total++; bad++;
                    $display("FAIL unexpected_word: got odat=%0h want no output", bus.odat);
                end else begin
                    e = q.pop_front();
                    chk("odat", 128'(bus.odat), 128'(e.dat));
                    chk("sop_eop_err", 128'({bus.osop, bus.oeop, bus.oframe_err}), 128'({e.sop, e.eop, e.err}));
                end
            end else begin
                if (run > 0) last_run = run;
                run = 0;
            end
            if (cnt_ordy && !bus.ordy) ordy_low++;
        end
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: got no finish want finish");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [NL-1:0][15:0] d;
        bus.ival = 1'b0; bus.isop = 1'b0; bus.ieop = 1'b0; bus.idat = '0;
        for (int l = 0; l < NL; l++) dir_par[l] = '0;
        dir_par[0] = cGEN_POLY[35:0];

        repeat (3) @(posedge iclk);
        #1;
        chk_reset_vals();
        ireset  = 1'b0;
        iclkena = 1'b1;
        idle(2, 1'b0);

        // word without isop in IDLE is dropped
        for (int l = 0; l < NL; l++) d[l] = 16'hA5A5;
        send(1'b0, 1'b0, d, 1'b0);
        idle(3, 1'b0);

        send_frame(239, 0, 1'b0, 1'b1);
        idle(5, 1'b0);

        dir_en = 1'b1;
        send_frame(239, 1, 1'b0, 1'b1);
        dir_en = 1'b0;
        idle(5, 1'b0);

        // back-to-back frames with ival held through the parity gap
        ordy_low = 0;
        cnt_ordy = 1'b1;
        send_frame(239, 2, 1'b0, 1'b1);
        send_frame(239, 2, 1'b0, 1'b1);
        idle(6, 1'b0);
        cnt_ordy = 1'b0;
        chk("ordy_low_cycles", 128'(ordy_low), 128'd6);
        chk("contiguous_oval", 128'(last_run), 128'd484);

        // one-word frame, then a restart inside a partial frame
        for (int l = 0; l < NL; l++) d[l] = 16'(16'h1234 + l);
        send(1'b1, 1'b1, d, 1'b0);
        idle(4, 1'b0);
        send_frame(5, 2, 1'b0, 1'b0);
        send_frame(239, 2, 1'b0, 1'b1);
        idle(5, 1'b0);

        send_frame(239, 2, 1'b1, 1'b1);
        idle(8, 1'b0);

        // reset in the middle of a frame
        send_frame(120, 2, 1'b0, 1'b0);
        @(negedge iclk); #1;
        ireset = 1'b1;
        #1;
        chk_reset_vals();
        chk("queue_empty_at_reset", 128'(q.size()), 128'd0);
        q.delete();
        m_in = 1'b0;
        @(posedge iclk); #1;
        ireset = 1'b0;
        idle(2, 1'b0);
        send_frame(239, 2, 1'b0, 1'b1);
        idle(5, 1'b0);

        // short frame, ieop at word 100
        send_frame(101, 2, 1'b0, 1'b1);
        idle(5, 1'b0);

        for (int n = 0; n < 50 && q.size() != 0; n++) idle(1, 1'b0);
        chk("queue_drained", 128'(q.size()), 128'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule

`default_nettype wire
